// File: rtl/k503x_sprite_scan_pkg.sv
// Shared types, FSM encoding and the vertical hit test for the k503x sprite line selector.
package k503x_pkg;

    localparam int unsigned ENTRY_BYTES = 2;
    localparam int unsigned HIT_IDX_W   = 8;
    localparam int unsigned HIT_ROW_W   = 7;

    // Fields are sized for the largest legal configuration; the top trims them.
    typedef struct packed {
        logic [HIT_IDX_W-1:0] idx;
        logic [HIT_ROW_W-1:0] row;
        logic                 hflip;
        logic [5:0]           color;
    } k503x_hit_t;

    typedef enum logic [2:0] {
        StIdle, StRdY, StRdAttr, StEval, StPush, StFin
    } k503x_state_e;

    function automatic logic f_hit(input logic [7:0] y, input logic [7:0] vline,
                                   input int unsigned log2_h);
        logic [7:0] sum;
        sum = y + vline;
        return (sum >> log2_h) == (8'hFF >> log2_h);
    endfunction

endpackage

// File: rtl/k503x_sprite_scan_if.sv
// Hit-entry handshake between the sprite line selector (master) and the line-buffer drawer.
interface k503x_sprite_scan_if #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned ROW_W = 4
);
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [IDX_W-1:0] OUT_IDX;
    logic [ROW_W-1:0] OUT_ROW;
    logic             OUT_HFLIP;
    logic [5:0]       OUT_COLOR;

    modport master (output OUT_VALID, OUT_IDX, OUT_ROW, OUT_HFLIP, OUT_COLOR, input OUT_READY);
    modport slave  (input OUT_VALID, OUT_IDX, OUT_ROW, OUT_HFLIP, OUT_COLOR, output OUT_READY);
endinterface

// File: rtl/k503x_sprite_scan_hit_fifo.sv
// Hit queue: power-of-2 circular FIFO with synchronous flush; flush wins over push and pop.
module k503x_hit_fifo
    import k503x_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter type T = k503x_hit_t,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    T                 mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the top gates the data with the valid flag.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/k503x_sprite_scan.sv
// Per-scanline sprite selector: scans object RAM, queues vertical hits for the drawer.
// Optional `K503X_FLIP_SCREEN_EN adds FLIP_SCREEN (inverted line and flips).
module k503x_sprite_scan
    import k503x_pkg::*;
#(
    parameter int unsigned NUM_SPR      = 24,
    parameter int unsigned SPR_H        = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned MAX_PER_LINE = 8,
    localparam int unsigned ADDR_W = $clog2(2 * NUM_SPR),
    localparam int unsigned IDX_W  = $clog2(NUM_SPR),
    localparam int unsigned LOG2_H = $clog2(SPR_H)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               LINE_START,
    input  logic [7:0]         VCNT,
`ifdef K503X_FLIP_SCREEN_EN
    input  logic               FLIP_SCREEN,
`endif
    output logic [ADDR_W-1:0]  OA,
    input  logic [7:0]         OB,
    k503x_sprite_scan_if.master hit_bus,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVF
);

    localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

    localparam logic [2:0] Idle   = StIdle;
    localparam logic [2:0] RdY    = StRdY;
    localparam logic [2:0] RdAttr = StRdAttr;
    localparam logic [2:0] Eval   = StEval;
    localparam logic [2:0] Push   = StPush;
    localparam logic [2:0] Fin    = StFin;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       vline_q, vline_d, y_q, y_d, attr_q, attr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             scr_flip;

`ifdef K503X_FLIP_SCREEN_EN
    logic flip_q, flip_d;
    assign scr_flip = flip_q;
`else
    assign scr_flip = 1'b0;
`endif

    logic                         fifo_push, fifo_flush, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    k503x_hit_t                   push_rec, pop_data;
    logic                         last_entry, eval_hit, vflip;
    logic [LOG2_H-1:0]            row_raw;

    assign last_entry = (idx_q == IDX_W'(NUM_SPR - 1));
    assign eval_hit   = f_hit(y_q, vline_q, LOG2_H);
    // Low bits of the wrapped sum are all the row needs.
    assign row_raw    = y_q[LOG2_H-1:0] + vline_q[LOG2_H-1:0];
    assign vflip      = attr_q[7] ^ scr_flip;

    always_comb begin
        push_rec       = '0;
        push_rec.idx   = HIT_IDX_W'(idx_q);
        push_rec.row   = HIT_ROW_W'(row_raw ^ {LOG2_H{vflip}});
        push_rec.hflip = attr_q[6] ^ scr_flip;
        push_rec.color = attr_q[5:0];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vline_d    = vline_q;
        y_d        = y_q;
        attr_d     = attr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
`ifdef K503X_FLIP_SCREEN_EN
        flip_d     = flip_q;
`endif
        if (LINE_START) begin
            fifo_flush = (state_q != Idle);
            state_d    = RdY;
            idx_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
`ifdef K503X_FLIP_SCREEN_EN
            flip_d     = FLIP_SCREEN;
            vline_d    = FLIP_SCREEN ? ~VCNT : VCNT;
`else
            vline_d    = VCNT;
`endif
        end else begin
            case (state_q)
                RdY:    state_d = RdAttr;
                RdAttr: begin
                    y_d     = OB;
                    state_d = Eval;
                end
                Eval: begin
                    attr_d = OB;
                    if (eval_hit && cnt_q < CNT_W'(MAX_PER_LINE)) begin
                        state_d = Push;
                    end else begin
                        if (eval_hit) ovf_d = 1'b1;
                        if (last_entry) begin
                            state_d = Fin;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = RdY;
                        end
                    end
                end
                Push: begin
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if (last_entry) begin
                            state_d = Fin;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = RdY;
                        end
                    end
                end
                Fin:     state_d = Idle;
                default: state_d = Idle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= Idle;
            idx_q   <= '0;
            vline_q <= '0;
            y_q     <= '0;
            attr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef K503X_FLIP_SCREEN_EN
            flip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vline_q <= vline_d;
            y_q     <= y_d;
            attr_q  <= attr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef K503X_FLIP_SCREEN_EN
            flip_q  <= flip_d;
`endif
        end
    end

    always_comb begin
        OA = '0;
        if (state_q == RdY)    OA = ADDR_W'(ENTRY_BYTES * idx_q);
        if (state_q == RdAttr) OA = ADDR_W'(ENTRY_BYTES * idx_q + 1);
    end

    assign BUSY = (state_q != Idle);
    assign DONE = (state_q == Fin);
    assign OVF  = ovf_q;

    assign fifo_pop          = hit_bus.OUT_VALID & hit_bus.OUT_READY;
    assign hit_bus.OUT_VALID = ~fifo_empty;
    assign hit_bus.OUT_IDX   = fifo_empty ? '0 : IDX_W'(pop_data.idx);
    assign hit_bus.OUT_ROW   = fifo_empty ? '0 : LOG2_H'(pop_data.row);
    assign hit_bus.OUT_HFLIP = fifo_empty ? 1'b0 : pop_data.hflip;
    assign hit_bus.OUT_COLOR = fifo_empty ? '0 : pop_data.color;

    logic unused_bits;
    assign unused_bits = ^{pop_data.idx >> IDX_W, pop_data.row >> LOG2_H, fifo_count};

    k503x_hit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (k503x_hit_t)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_k503x_sprite_scan.sv
// Scoreboard bench for k503x_sprite_scan: reference model queues expected hits, monitor pops.
module tb_k503x_sprite_scan;

    localparam int NUM_SPR      = 24;
    localparam int SPR_H        = 16;
    localparam int MAX_PER_LINE = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       LINE_START = 1'b0;
    logic       flip_in = 1'b0;
    logic [7:0] VCNT = 8'h00;
    logic [7:0] OB;
    logic [5:0] OA;
    logic       BUSY, DONE, OVF;

    logic [7:0] oram [2*NUM_SPR];

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int ready_mode = 0;  // 0: held low, 1: held high, 2: random
    bit [15:0] exp_q [$];
    bit [15:0] got, want;

    k503x_sprite_scan_if #(.IDX_W(5), .ROW_W(4)) bus ();

    k503x_sprite_scan dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LINE_START (LINE_START),
        .VCNT       (VCNT),
`ifdef K503X_FLIP_SCREEN_EN
        .FLIP_SCREEN(flip_in),
`endif
        .OA         (OA),
        .OB         (OB),
        .hit_bus    (bus),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVF        (OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) OB <= (OA < 6'd48) ? oram[OA] : 8'h00;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        bus.OUT_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       bus.OUT_READY = 1'b0;
                1:       bus.OUT_READY = 1'b1;
                default: bus.OUT_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge CLK) begin
        if (!RESET && DONE) done_cnt++;
        if (!RESET && bus.OUT_VALID && bus.OUT_READY) begin
            xfer_cnt++;
            got = {bus.OUT_IDX, bus.OUT_ROW, bus.OUT_HFLIP, bus.OUT_COLOR};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h, required no entry", got);
            end else begin
                want = exp_q.pop_front();
                chk("sb_entry", got, want);
            end
        end
    end

    // Reference: a sprite covers lines where (Y + vline) mod 256 lies in the top SPR_H values.
    task automatic model_line(input logic [7:0] v, input logic f, output bit ovf);
        int n, s, row;
        logic [7:0] a, vl;
        n = 0;
        ovf = 1'b0;
        vl = f ? ~v : v;
        for (int i = 0; i < NUM_SPR; i++) begin
            s = (int'(oram[2*i]) + int'(vl)) % 256;
            a = oram[2*i+1];
            if (s >= 256 - SPR_H) begin
                if (n < MAX_PER_LINE) begin
                    row = s % SPR_H;
                    if (a[7] ^ f) row = SPR_H - 1 - row;
                    exp_q.push_back({5'(i), 4'(row), a[6] ^ f, a[5:0]});
                    n++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_line(input logic [7:0] v);
        VCNT = v;
        LINE_START = 1'b1;
        step(1);
        LINE_START = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin
            step(1);
            k++;
        end
        chk(name, done_cnt != d0, 1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || bus.OUT_VALID) && k < 3000) begin
            step(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic fill_nohit(input logic [7:0] v);
        for (int i = 0; i < NUM_SPR; i++) begin
            oram[2*i]   = 8'h00 - v;
            oram[2*i+1] = 8'($urandom);
        end
    endtask

    task automatic run_line(input string name, input logic [7:0] v, input logic f,
                            input int mode, input bit use_model);
        int d0;
        bit ovf_exp;
        d0 = done_cnt;
        flip_in = f;
        ovf_exp = 1'b0;
        if (use_model) model_line(v, flip_in, ovf_exp);
        ready_mode = mode;
        start_line(v);
        wait_done({name, "_done_seen"}, d0);
        drain({name, "_drain"});
        step(2);
        chk({name, "_ovf"}, OVF, ovf_exp);
        chk({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, d1, x0, k;
        bit ovf_tmp;
        for (int i = 0; i < 2 * NUM_SPR; i++) oram[i] = 8'h00;

        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        chk("rst_oa", OA, 0);
        chk("rst_valid", bus.OUT_VALID, 0);
        chk("rst_idx", bus.OUT_IDX, 0);
        chk("rst_row", bus.OUT_ROW, 0);
        chk("rst_hflip", bus.OUT_HFLIP, 0);
        chk("rst_color", bus.OUT_COLOR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovf", OVF, 0);

        // Entry 3 hits at sum 0xF0: row 0, then row 15 with vflip.
        fill_nohit(8'h20);
        oram[6] = 8'hD0;
        oram[7] = 8'h25;
        exp_q.push_back({5'd3, 4'd0, 1'b0, 6'h25});
        run_line("t2a", 8'h20, 1'b0, 1, 1'b0);
        oram[7] = 8'hC5;
        exp_q.push_back({5'd3, 4'd15, 1'b1, 6'h05});
        run_line("t2b", 8'h20, 1'b0, 1, 1'b0);

        fill_nohit(8'h20);
        oram[10] = 8'hE5;
        x0 = xfer_cnt;
        run_line("t3a", 8'h20, 1'b0, 1, 1'b0);
        chk("t3a_no_hit", xfer_cnt - x0, 0);
        fill_nohit(8'h10);
        oram[14] = 8'hEF;
        oram[15] = 8'h11;
        exp_q.push_back({5'd7, 4'd15, 1'b0, 6'h11});
        run_line("t3b", 8'h10, 1'b0, 1, 1'b0);

        // Every entry hits: only the first MAX_PER_LINE come out.
        for (int i = 0; i < NUM_SPR; i++) begin
            oram[2*i]   = 8'(8'hB0 + i % 16);
            oram[2*i+1] = 8'($urandom);
        end
        x0 = xfer_cnt;
        run_line("t4", 8'h40, 1'b0, 1, 1'b1);
        chk("t4_xfers", xfer_cnt - x0, 8);
        chk("t4_ovf_set", OVF, 1);

        // Fill the FIFO, then start a line from idle so its first push stalls.
        fill_nohit(8'h20);
        for (int i = 0; i < 10; i++) oram[2*i] = 8'(8'hD0 + i);
        ready_mode = 0;
        flip_in = 1'b0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        model_line(8'h20, flip_in, ovf_tmp);
        start_line(8'h20);
        wait_done("t5a_done_seen", d0);
        step(3);
        chk("t5a_ovf", OVF, 1);
        chk("t5a_valid", bus.OUT_VALID, 1);
        d1 = done_cnt;
        model_line(8'h2A, flip_in, ovf_tmp);
        start_line(8'h2A);
        step(60);
        chk("t5_stall_busy", BUSY, 1);
        chk("t5_stall_no_done", done_cnt - d1, 0);
        chk("t5_stall_no_xfer", xfer_cnt - x0, 0);
        ready_mode = 1;
        wait_done("t5b_done_seen", d1);
        drain("t5_drain");
        chk("t5_xfers", xfer_cnt - x0, 14);
        chk("t5b_done_once", done_cnt - d1, 1);

        // Abort at entry 10 with two entries queued.
        fill_nohit(8'h20);
        oram[0]  = 8'hD0;
        oram[2]  = 8'hD0;
        oram[10] = 8'hC8;
        oram[40] = 8'hC0;
        ready_mode = 0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        model_line(8'h20, flip_in, ovf_tmp);
        start_line(8'h20);
        k = 0;
        while (OA != 6'd20 && k < 500) begin
            step(1);
            k++;
        end
        chk("t6_reach_i10", OA, 20);
        chk("t6_queued", bus.OUT_VALID, 1);
        exp_q.delete();
        model_line(8'h30, flip_in, ovf_tmp);
        start_line(8'h30);
        chk("t6_flushed", bus.OUT_VALID, 0);
        chk("t6_restart_oa", OA, 0);
        chk("t6_busy", BUSY, 1);
        ready_mode = 1;
        wait_done("t6_done_seen", d0);
        drain("t6_drain");
        step(2);
        chk("t6_done_once", done_cnt - d0, 1);
        chk("t6_xfers", xfer_cnt - x0, 2);

        // Reset mid-scan, also overriding a coincident LINE_START.
        for (int i = 0; i < NUM_SPR; i++) oram[2*i] = 8'(8'hB0 + i % 16);
        ready_mode = 0;
        model_line(8'h40, flip_in, ovf_tmp);
        start_line(8'h40);
        k = 0;
        while (!OVF && k < 500) begin
            step(1);
            k++;
        end
        chk("t1_ovf_before", OVF, 1);
        chk("t1_busy_before", BUSY, 1);
        RESET = 1'b1;
        LINE_START = 1'b1;
        step(1);
        RESET = 1'b0;
        LINE_START = 1'b0;
        exp_q.delete();
        chk("t1_busy", BUSY, 0);
        chk("t1_valid", bus.OUT_VALID, 0);
        chk("t1_oa", OA, 0);
        chk("t1_ovf", OVF, 0);
        step(3);
        chk("t1_still_idle", BUSY, 0);

        for (int r = 0; r < 6; r++) begin
            logic [7:0] v;
            logic f;
            v = 8'($urandom);
`ifdef K503X_FLIP_SCREEN_EN
            f = 1'($urandom_range(0, 1));
`else
            f = 1'b0;
`endif
            for (int i = 0; i < NUM_SPR; i++) begin
                if ($urandom_range(0, 1) == 1)
                    oram[2*i] = 8'(256 - SPR_H - int'(f ? ~v : v) + $urandom_range(0, SPR_H - 1));
                else
                    oram[2*i] = 8'($urandom);
                oram[2*i+1] = 8'($urandom);
            end
            run_line("rnd", v, f, 2, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
